// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and defaults for the data-memory responder
// Contents: state_e (IDLE/BUSY/RESP), DEPTH_WORDS_DEF, LATENCY_DEF, WORD_W
package dmem_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
   localparam int DEPTH_WORDS_DEF = 256;
   localparam int LATENCY_DEF = 2;
   localparam int WORD_W = 32;
endpackage

// File: rtl/dmem_if.sv
// dmem_if: load/store request and response bundle between pipeline and responder
// Modports: master (pipeline drives req_*), slave (responder drives req_ready, rsp_*, stall)
interface dmem_if;
   import dmem_pkg::*;
   logic              req_valid;
   logic              req_write;
   logic [31:0]       req_addr;
   logic [WORD_W-1:0] req_wdata;
   logic              req_ready;
   logic              rsp_valid;
   logic [WORD_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              stall;
   modport master (output req_valid, req_write, req_addr, req_wdata,
                   input req_ready, rsp_valid, rsp_rdata, rsp_err, stall);
   modport slave (input req_valid, req_write, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err, stall);
endinterface

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous word RAM with registered read data
// Ports: clk, we_i (write enable), addr_i (word index), wdata_i, rdata_o (value at addr_i before the edge)
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = DEPTH_WORDS_DEF,
   parameter int AW = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [WORD_W-1:0] wdata_i,
   output logic [WORD_W-1:0] rdata_o
);
   // contents start at zero and are deliberately outside the reset domain
   logic [WORD_W-1:0] mem_q [DEPTH] = '{default: '0};
   always_ff @(posedge clk) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      rdata_o <= mem_q[addr_i];
   end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEMORY-stage target; one request at a time, fixed latency, one-cycle response
// Ports: clk, reset (sync, active-high), bus (dmem_if.slave)
// Option: define DMEM_ALIGN_CHECK_EN to flag misaligned accesses with rsp_err and suppress them
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
   parameter int LATENCY = LATENCY_DEF
) (
   input logic   clk,
   input logic   reset,
   dmem_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);
`ifdef DMEM_ALIGN_CHECK_EN
   localparam bit ALIGN_CHK = 1'b1;
`else
   localparam bit ALIGN_CHK = 1'b0;
`endif
   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              write_q, err_q;
   logic [AW-1:0]     idx_q;
   logic [WORD_W-1:0] wdata_q, ram_rdata;
   logic              accept, access, we;
   assign accept = state_q == IDLE && bus.req_valid;
   // the access happens on the edge that leaves BUSY; reset on that edge cancels it
   assign access = state_q == BUSY && cnt_q == '0;
   assign we = access && write_q && !err_q && !reset;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
      end
      if (accept) begin
         write_q <= bus.req_write;
         idx_q <= bus.req_addr[AW+1:2];
         wdata_q <= bus.req_wdata;
         err_q <= ALIGN_CHK && (bus.req_addr[1:0] != 2'b00);
      end
   end
   always_comb begin
      state_d = state_q == IDLE ? (bus.req_valid ? BUSY : IDLE)
              : state_q == BUSY ? (cnt_q == '0 ? RESP : BUSY)
              : IDLE;
      cnt_d = state_q == IDLE ? 4'(LATENCY - 1)
            : (state_q == BUSY && cnt_q != '0) ? cnt_q - 4'd1
            : cnt_q;
   end
   dmem_array #(.DEPTH(DEPTH_WORDS)) u_array (
      .clk     (clk),
      .we_i    (we),
      .addr_i  (idx_q),
      .wdata_i (wdata_q),
      .rdata_o (ram_rdata)
   );
   assign bus.req_ready = state_q == IDLE;
   assign bus.stall = state_q == BUSY;
   assign bus.rsp_valid = state_q == RESP;
   assign bus.rsp_err = state_q == RESP && err_q;
   assign bus.rsp_rdata = (state_q == RESP && !write_q && !err_q) ? ram_rdata : '0;
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the five-stage pipeline: the target end of the MEMORY stage's load/store traffic. It accepts one request at a time over a valid/ready handshake, waits a fixed number of cycles, performs a word read or write on an internal array, and returns a one-cycle response. `stall` tells the pipeline to freeze its upstream latches while an access is in flight.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words in the array; power of two, 2 to 4096.
- `LATENCY`, 2: wait cycles between acceptance and response; 1 to 15.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous reset, active-high.
- `req_valid` input 1: request present.
- `req_write` input 1: 1 = store, 0 = load.
- `req_addr` input 32: byte address from ALU result.
- `req_wdata` input 32: store data (B operand).
- `req_ready` output 1: responder can accept a request this cycle.
- `rsp_valid` output 1: one-cycle response strobe.
- `rsp_rdata` output 32: load data, valid with `rsp_valid`; 0 for stores.
- `rsp_err` output 1: misaligned access flag, valid with `rsp_valid`.
- `stall` output 1: pipeline hold request.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch write flag, address and wdata; load `wait_cnt`=LATENCY-1; go to BUSY.
- BUSY:
  - `req_ready`=0 and `stall`=1.
  - Decrement `wait_cnt`.
  - When `wait_cnt`==0, perform the access at the clock edge and go to RESP.
  - Load: capture `array[idx]` into the response register.
  - Store: write `array[idx]`; response data 0.
- RESP:
  - `rsp_valid`=1 for exactly one cycle; `req_ready`=0; `stall`=0.
  - Next state is IDLE.
- `req_valid` outside IDLE is ignored; the requester must hold it until accepted.
- Word index `idx` = `req_addr[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so out-of-range addresses wrap modulo DEPTH_WORDS.
- Stores are full-word only.
- A store followed by a load to the same address returns the new data.
- Array contents are zero at time 0 and are not affected by `reset`.

## Timing
- After a reset edge:
  - state IDLE
  - `req_ready`=1
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `stall`=0
- Acceptance at edge k gives:
  - BUSY in cycles k+1 through k+LATENCY;
  - `rsp_valid` high in cycle k+LATENCY+1;
  - IDLE again at k+LATENCY+2.
- Throughput: one request per LATENCY+2 cycles.
- `rsp_rdata` and `rsp_err` return to 0 whenever `rsp_valid`=0.
- Reset during BUSY aborts the access: a pending store is discarded and no `rsp_valid` is produced.
- Reset during RESP drops `rsp_valid` at that edge.
- `reset` and `req_valid` in the same cycle: reset wins; the request is not accepted.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - A request with `req_addr[1:0]`!=0 is still accepted and timed normally.
  - The array is not accessed, and a store does not write.
  - The response has `rsp_err`=1 and `rsp_rdata`=0.
- `DMEM_ALIGN_CHECK_EN` undefined:
  - `req_addr[1:0]` is ignored.
  - `rsp_err` is tied 0.
  - The port remains present.

## Structure
- Shared package `dmem_pkg`:
  - state enum (IDLE/BUSY/RESP);
  - default DEPTH_WORDS and LATENCY constants;
  - word-width constant (32).
- One sub-module, `dmem_array`: single-port synchronous RAM with `we`, `addr`, `wdata`, and registered `rdata`. The FSM, wait counter and response register live in `dmem_responder`.

## Test plan
- Reset then idle: hold `reset` 2 cycles, release -> `req_ready`=1, `stall`=0, `rsp_valid`=0 for 10 cycles.
- Store then load, LATENCY=2: store 0xDEADBEEF to 0x10, then load 0x10.
  - Store: `rsp_valid` 3 cycles after acceptance with `rsp_rdata`=0.
  - Load: `rsp_rdata`=0xDEADBEEF.
  - `stall` high exactly 2 cycles per access.
- Wrap, DEPTH_WORDS=256: store 0x12345678 to 0x400, load 0x000 -> 0x12345678.
- Back-to-back: hold `req_valid` high for two loads -> second accepted 4 cycles after the first; no request lost or duplicated.
- Reset mid-BUSY: store 0xAAAA5555 to 0x20, assert `reset` in the first BUSY cycle -> no `rsp_valid`; a later load of 0x20 returns the previous value (0).
- Misaligned store to 0x22 followed by a load of 0x20:
  - With `DMEM_ALIGN_CHECK_EN`: `rsp_err`=1, `rsp_rdata`=0, memory unchanged.
  - Without `DMEM_ALIGN_CHECK_EN`: the word at 0x20 is written and `rsp_err`=0.
